// File: rtl/instmemory_param.sv
`default_nettype none
// ============================================================================
// Module      : instmemory_param
// Description : Parameterised instruction memory. On reset it walks every
//               word and fills it with NOP_WORD. It then serves registered
//               fetches with one cycle of latency, and takes byte-enabled
//               writes on an independent write port.
// Revision    : 1.0 - initial release
// ============================================================================
module instmemory_param #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(32'h00000013)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  fetch_stall,
    output logic [DATA_W-1:0]     instruct,
    output logic                  instruct_valid,
    output logic                  fault,
    output logic                  ready,
    input  logic                  wr_en,
    input  logic [31:0]           wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be
);

    localparam int          BYTES    = DATA_W / 8;
    localparam int          OFF_W    = $clog2(BYTES);
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [31:0] OFF_MASK = 32'(BYTES - 1);
    localparam logic [31:0] DEPTH_32 = 32'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   counter;
    logic [DATA_W-1:0]  mem [DEPTH];

    // Word addresses are kept at the full 32 bits so that an out-of-range
    // address is caught here and never wraps onto a low word.
    logic [31:0]        fetch_word;
    logic [31:0]        wr_word;
    logic               fetch_ok;
    logic               wr_ok;
    logic [IDX_W-1:0]   fetch_idx;
    logic [IDX_W-1:0]   wr_idx;
    logic [DATA_W-1:0]  wr_merged;
    logic [DATA_W-1:0]  fetch_data;

    assign fetch_word = fetch_addr >> OFF_W;
    assign wr_word    = wr_addr >> OFF_W;
    assign fetch_idx  = fetch_word[IDX_W-1:0];
    assign wr_idx     = wr_word[IDX_W-1:0];

    assign fetch_ok = ((fetch_addr & OFF_MASK) == 32'd0) && (fetch_word < DEPTH_32);
    assign wr_ok    = (state == RUN) && wr_en
                   && ((wr_addr & OFF_MASK) == 32'd0) && (wr_word < DEPTH_32);

    // Merge the enabled byte lanes of the write data into the stored word.
    always_comb begin
        wr_merged = mem[wr_idx];
        for (int i = 0; i < BYTES; i++) begin
            if (wr_be[i]) begin
                wr_merged[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    // Write-first bypass: a fetch of the word being written sees the new data.
    assign fetch_data = (wr_ok && (wr_idx == fetch_idx)) ? wr_merged : mem[fetch_idx];

    // Storage update: a clear sweep in INIT, port writes in RUN, nothing in reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT) begin
                mem[counter] <= NOP_WORD;
            end else if (wr_ok) begin
                mem[wr_idx] <= wr_merged;
            end
        end
    end

    // Control FSM and registered fetch outputs; a stall freezes the outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= INIT;
            counter        <= '0;
            ready          <= 1'b0;
            instruct       <= '0;
            instruct_valid <= 1'b0;
            fault          <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    counter <= counter + 1'b1;
                    if (counter == LAST_IDX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (!fetch_stall) begin
                        if (fetch_req) begin
                            instruct_valid <= 1'b1;
                            if (fetch_ok) begin
                                instruct <= fetch_data;
                                fault    <= 1'b0;
                            end else begin
                                instruct <= NOP_WORD;
                                fault    <= 1'b1;
                            end
                        end else begin
                            instruct_valid <= 1'b0;
                            fault          <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instmemory_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_instmemory_param
// Description : Self-checking bench for instmemory_param (DEPTH=16). A
//               word-array reference model is compared every cycle, and
//               directed vectors are also checked against literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instmemory_param;

    localparam int          DEPTH = 16;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_stall;
    logic [31:0] instruct;
    logic        instruct_valid;
    logic        fault;
    logic        ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    int n_cmp = 0;
    int n_bad = 0;

    instmemory_param #(
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .NOP_WORD(NOP)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .fetch_req     (fetch_req),
        .fetch_addr    (fetch_addr),
        .fetch_stall   (fetch_stall),
        .instruct      (instruct),
        .instruct_valid(instruct_valid),
        .fault         (fault),
        .ready         (ready),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_be         (wr_be)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: an array of words plus a count of clear cycles left
    // ------------------------------------------------------------------
    logic [31:0] m_mem [DEPTH];
    int          m_init_left = 0;
    bit          m_on = 0;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic        m_ready;

    task automatic model_step();
        int widx;
        int fidx;
        if (reset) begin
            m_on        = 1;
            m_init_left = DEPTH;
            m_instr     = 32'd0;
            m_valid     = 1'b0;
            m_fault     = 1'b0;
            m_ready     = 1'b0;
        end else if (m_init_left > 0) begin
            m_mem[DEPTH - m_init_left] = NOP;
            m_init_left--;
            m_ready = (m_init_left == 0);
        end else begin
            widx = int'(wr_addr / 4);
            if (wr_en && (wr_addr % 4 == 0) && (wr_addr / 4 < DEPTH)) begin
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) m_mem[widx][8*b +: 8] = wr_data[8*b +: 8];
            end
            if (!fetch_stall) begin
                if (fetch_req) begin
                    m_valid = 1'b1;
                    if ((fetch_addr % 4 == 0) && (fetch_addr / 4 < DEPTH)) begin
                        fidx    = int'(fetch_addr / 4);
                        m_instr = m_mem[fidx];
                        m_fault = 1'b0;
                    end else begin
                        m_instr = NOP;
                        m_fault = 1'b1;
                    end
                end else begin
                    m_valid = 1'b0;
                    m_fault = 1'b0;
                end
            end
        end
    endtask

    // Compare process: step the model on each rising edge, check just after it
    initial begin
        forever begin
            @(posedge clock);
            model_step();
            #1;
            if (m_on) begin
                check("model ready", {31'd0, ready}, {31'd0, m_ready});
                check("model valid", {31'd0, instruct_valid}, {31'd0, m_valid});
                check("model fault", {31'd0, fault}, {31'd0, m_fault});
                check("model instruct", instruct, m_instr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus; inputs change only on falling edges
    // ------------------------------------------------------------------
    task automatic fetch(input logic [31:0] a);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge clock);
        fetch_req  = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] ins, input logic v, input logic f);
        check({name, " instruct"}, instruct, ins);
        check({name, " valid"}, {31'd0, instruct_valid}, {31'd0, v});
        check({name, " fault"}, {31'd0, fault}, {31'd0, f});
    endtask

    task automatic wait_init(input string name);
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clock);
            check(name, {31'd0, ready}, (i == DEPTH) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 32'd0; fetch_stall = 1'b0;
        wr_en = 1'b0; wr_addr = 32'd0; wr_data = 32'd0; wr_be = 4'd0;
        @(negedge clock);
        expect_out("reset", 32'd0, 1'b0, 1'b0);
        check("reset ready", {31'd0, ready}, 32'd0);
        reset = 1'b0;
        wait_init("init ready");

        fetch(32'h4);
        expect_out("fetch4", 32'h00000013, 1'b1, 1'b0);

        write(32'h0, 32'h00A200B3, 4'b1111);
        fetch(32'h0);
        expect_out("fetch0", 32'h00A200B3, 1'b1, 1'b0);
        @(negedge clock);
        expect_out("idle hold", 32'h00A200B3, 1'b0, 1'b0);

        write(32'h4, 32'hFFFFFFFF, 4'b0010);
        fetch(32'h4);
        expect_out("byte lane1", 32'h0000FF13, 1'b1, 1'b0);

        fetch(32'h2);
        expect_out("misaligned", 32'h00000013, 1'b1, 1'b1);
        fetch(32'h40);
        expect_out("out of range", 32'h00000013, 1'b1, 1'b1);
        write(32'h41, 32'h12345678, 4'b1111);
        write(32'h40, 32'h12345678, 4'b1111);
        fetch(32'h0);
        expect_out("bad writes ignored", 32'h00A200B3, 1'b1, 1'b0);

        wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
        fetch(32'h8);
        wr_en = 1'b0;
        expect_out("write-first full", 32'hDEADBEEF, 1'b1, 1'b0);
        wr_en = 1'b1; wr_addr = 32'h8; wr_data = 32'h000000AA; wr_be = 4'b0001;
        fetch(32'h8);
        wr_en = 1'b0;
        expect_out("write-first merge", 32'hDEADBEAA, 1'b1, 1'b0);

        fetch_stall = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h0;
        wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'h11223344; wr_be = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            wr_en = 1'b0;
            expect_out("stall hold", 32'hDEADBEAA, 1'b1, 1'b0);
        end
        fetch_stall = 1'b0; fetch_req = 1'b0;
        @(negedge clock);
        expect_out("after stall", 32'hDEADBEAA, 1'b0, 1'b0);
        fetch(32'hC);
        expect_out("write during stall", 32'h11223344, 1'b1, 1'b0);

        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hCAFEF00D; wr_be = 4'b1111;
        @(negedge clock);
        expect_out("run reset", 32'd0, 1'b0, 1'b0);
        check("run reset ready", {31'd0, ready}, 32'd0);
        reset = 1'b0; wr_en = 1'b0;
        fetch_req = 1'b1; fetch_addr = 32'h0;
        wait_init("reinit ready");
        fetch_req = 1'b0;
        fetch(32'h0);
        expect_out("recleared 0", 32'h00000013, 1'b1, 1'b0);
        fetch(32'h4);
        expect_out("recleared 4", 32'h00000013, 1'b1, 1'b0);

        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        wait_init("mid-init reset ready");
        fetch(32'h8);
        expect_out("after mid-init reset", 32'h00000013, 1'b1, 1'b0);

        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
